refill_arbiter: RTL

Shares the single external memory read port between the instruction-cache and data-cache miss paths. Accepts line-fill requests from two requesters, arbitrates round-robin, and issues one memory burst per request. Collects `BEATS` read beats into a full cache line and returns the line to the winning requester with a one-cycle fill strobe. Sits between the cache miss logic and the memory/bus interface.

---
 rtl/refill_pkg.sv | 21 ++
 rtl/refill_arbiter_if.sv | 35 +++
 rtl/rr_arb2.sv | 23 ++
 rtl/refill_arbiter.sv | 121 ++++++++++++
 4 files changed

// File: rtl/refill_pkg.sv
// Shared constants for the cache refill arbiter: FSM encodings, requester ids, default widths.
package refill_pkg;

  localparam int unsigned DEF_LINE_WIDTH      = 512;
  localparam int unsigned DEF_BEAT_WIDTH      = 32;
  localparam int unsigned DEF_LINE_ADDR_WIDTH = 26;
  localparam int unsigned MEM_ADDR_WIDTH      = 32;
  localparam int unsigned LINE_OFFSET_BITS    = 6;
  localparam int unsigned STATE_WIDTH         = 2;

  typedef logic [STATE_WIDTH-1:0] state_t;

  localparam state_t S_IDLE    = 2'd0;
  localparam state_t S_ISSUE   = 2'd1;
  localparam state_t S_BEAT    = 2'd2;
  localparam state_t S_DELIVER = 2'd3;

  localparam logic REQ_ICACHE = 1'b0;
  localparam logic REQ_DCACHE = 1'b1;

endpackage

// File: rtl/refill_arbiter_if.sv
// Requester, fill-return and memory read-port signals of the refill arbiter.
interface refill_arbiter_if #(
  parameter int unsigned LINE_WIDTH      = refill_pkg::DEF_LINE_WIDTH,
  parameter int unsigned BEAT_WIDTH      = refill_pkg::DEF_BEAT_WIDTH,
  parameter int unsigned LINE_ADDR_WIDTH = refill_pkg::DEF_LINE_ADDR_WIDTH
);

  logic                       req0;
  logic [LINE_ADDR_WIDTH-1:0] addr0;
  logic                       req1;
  logic [LINE_ADDR_WIDTH-1:0] addr1;
  logic                       gnt0;
  logic                       gnt1;
  logic                       fill_valid;
  logic                       fill_id;
  logic [LINE_ADDR_WIDTH-1:0] fill_addr;
  logic [LINE_WIDTH-1:0]      fill_line;
  logic                       mem_req;
  logic [31:0]                mem_addr;
  logic                       mem_ack;
  logic                       mem_rvalid;
  logic [BEAT_WIDTH-1:0]      mem_rdata;
  logic                       busy;

  modport slave (
    input  req0, addr0, req1, addr1, mem_ack, mem_rvalid, mem_rdata,
    output gnt0, gnt1, fill_valid, fill_id, fill_addr, fill_line, mem_req, mem_addr, busy
  );

  modport master (
    output req0, addr0, req1, addr1, mem_ack, mem_rvalid, mem_rdata,
    input  gnt0, gnt1, fill_valid, fill_id, fill_addr, fill_line, mem_req, mem_addr, busy
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester not granted last wins.
module rr_arb2
  import refill_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt_c,
  output logic       id_c
);

  always_comb begin
    gnt_c = 2'b00;
    id_c  = REQ_ICACHE;
    if (req[0] && (!req[1] || last == REQ_DCACHE)) begin
      gnt_c = 2'b01;
      id_c  = REQ_ICACHE;
    end else if (req[1]) begin
      gnt_c = 2'b10;
      id_c  = REQ_DCACHE;
    end
  end

endmodule

// File: rtl/refill_arbiter.sv
// Shares one memory read port between I$ and D$ line fills: arbitrate, burst, assemble, deliver.
module refill_arbiter
  import refill_pkg::*;
#(
  parameter int unsigned LINE_WIDTH      = DEF_LINE_WIDTH,
  parameter int unsigned BEAT_WIDTH      = DEF_BEAT_WIDTH,
  parameter int unsigned BEATS           = LINE_WIDTH / BEAT_WIDTH,
  parameter int unsigned LINE_ADDR_WIDTH = DEF_LINE_ADDR_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  refill_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       last_q, last_d;
  logic                       id_q, id_d;
  logic [LINE_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0]      line_q, line_d;
  logic                       gnt0_q, gnt0_d;
  logic                       gnt1_q, gnt1_d;
  logic                       fill_valid_q, fill_valid_d;
  logic                       mem_req_q, mem_req_d;
  logic                       busy_q, busy_d;

  logic [1:0] arb_gnt;
  logic       arb_id;

  rr_arb2 u_arb (
    .req   ({bus.req1, bus.req0}),
    .last  (last_q),
    .gnt_c (arb_gnt),
    .id_c  (arb_id)
  );

  // Next-state and next-output logic; outputs are registered from the next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    id_d    = id_q;
    addr_d  = addr_q;
    line_d  = line_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (arb_gnt != 2'b00) begin
          state_d = S_ISSUE;
          gnt0_d  = arb_gnt[0];
          gnt1_d  = arb_gnt[1];
          id_d    = arb_id;
          last_d  = arb_id;
          addr_d  = (arb_id == REQ_DCACHE) ? bus.addr1 : bus.addr0;
        end
      end
      S_ISSUE: begin
        if (bus.mem_ack) begin
          state_d = S_BEAT;
          cnt_d   = '0;
        end
      end
      S_BEAT: begin
        if (bus.mem_rvalid) begin
          for (int k = 0; k < BEATS; k++) begin
            if (cnt_q == CNT_W'(k)) line_d[k*BEAT_WIDTH +: BEAT_WIDTH] = bus.mem_rdata;
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(BEATS - 1)) state_d = S_DELIVER;
        end
      end
      S_DELIVER: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    mem_req_d    = (state_d == S_ISSUE);
    fill_valid_d = (state_d == S_DELIVER);
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      last_q       <= REQ_DCACHE;
      id_q         <= REQ_ICACHE;
      addr_q       <= '0;
      line_q       <= '0;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      fill_valid_q <= 1'b0;
      mem_req_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
      id_q         <= id_d;
      addr_q       <= addr_d;
      line_q       <= line_d;
      gnt0_q       <= gnt0_d;
      gnt1_q       <= gnt1_d;
      fill_valid_q <= fill_valid_d;
      mem_req_q    <= mem_req_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.gnt0       = gnt0_q;
  assign bus.gnt1       = gnt1_q;
  assign bus.fill_valid = fill_valid_q;
  assign bus.fill_id    = id_q;
  assign bus.fill_addr  = addr_q;
  assign bus.fill_line  = line_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = MEM_ADDR_WIDTH'({addr_q, {LINE_OFFSET_BITS{1'b0}}});
  assign bus.busy       = busy_q;

endmodule
